bldc_commutator: RTL and testbench

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

---
 rtl/bldc_commutator.sv | 134 +++++++++++++
 tb/tb_bldc_commutator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: free-running 8-bit PWM, IDLE/DEAD/RUN sequencer,
// and registered gate drives with a dead-time gap at every step change.
module bldc_commutator #(
    parameter int DEAD_TIME = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        dir,
    input  logic [15:0] period,
    input  logic [7:0]  duty_cmd,
    output logic        duty,
    output logic [2:0]  rotateState,
    output logic        HIN_R,
    output logic        HIN_S,
    output logic        HIN_T,
    output logic        _LIN_R,
    output logic        _LIN_S,
    output logic        _LIN_T
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME);

    typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

    state_t      state, state_nx;
    logic [7:0]  dead_cnt, dead_nx;
    logic [15:0] step_cnt, step_nx;
    logic [2:0]  rot_nx;
    logic [7:0]  pwm_cnt, duty_q;
    logic        duty_nx, step_done;
    logic [2:0]  hi_on, lo_on, hin_nx;

    // Illegal steps (6, 7) land on step 0 whatever the direction.
    function automatic logic [2:0] advance(input logic [2:0] s, input logic fwd);
        if (s > 3'd5) return 3'd0;
        if (fwd) return (s == 3'd5) ? 3'd0 : s + 3'd1;
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

    assign duty_nx = (pwm_cnt < duty_q);
    // ">=" rather than "==" so a period shortened below the running count
    // still ends the step on the next compare instead of wrapping 16 bits.
    assign step_done = (period != 16'd0) &&
                       (({1'b0, step_cnt} + 17'd1) >= {1'b0, period});

    always_comb begin
        state_nx = state;
        dead_nx  = dead_cnt;
        step_nx  = step_cnt;
        rot_nx   = rotateState;
        if (!enable) begin
            state_nx = IDLE;
            dead_nx  = 8'd0;
            step_nx  = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = DEAD;
                    dead_nx  = DEAD_LOAD;
                    step_nx  = 16'd0;
                end
                DEAD: begin
                    dead_nx = dead_cnt - 8'd1;
                    if (dead_cnt <= 8'd1) state_nx = RUN;
                end
                RUN: begin
                    if (step_done) begin
                        step_nx  = 16'd0;
                        rot_nx   = advance(rotateState, dir);
                        state_nx = DEAD;
                        dead_nx  = DEAD_LOAD;
                    end else if (period != 16'd0) begin
                        step_nx = step_cnt + 16'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    dead_nx  = 8'd0;
                    step_nx  = 16'd0;
                end
            endcase
        end

        // Gates decode from the next state so they change on the same edge.
        hi_on = 3'b000;
        lo_on = 3'b000;
        if (state_nx == RUN) begin
            case (rot_nx)
                3'd0: begin hi_on = 3'b100; lo_on = 3'b010; end
                3'd1: begin hi_on = 3'b100; lo_on = 3'b001; end
                3'd2: begin hi_on = 3'b010; lo_on = 3'b001; end
                3'd3: begin hi_on = 3'b010; lo_on = 3'b100; end
                3'd4: begin hi_on = 3'b001; lo_on = 3'b100; end
                3'd5: begin hi_on = 3'b001; lo_on = 3'b010; end
                default: begin hi_on = 3'b000; lo_on = 3'b000; end
            endcase
        end
        hin_nx = hi_on & {3{duty_nx}};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            dead_cnt    <= 8'd0;
            step_cnt    <= 16'd0;
            rotateState <= 3'd0;
            pwm_cnt     <= 8'd0;
            duty_q      <= 8'd0;
            duty        <= 1'b0;
            HIN_R       <= 1'b0;
            HIN_S       <= 1'b0;
            HIN_T       <= 1'b0;
            _LIN_R      <= 1'b1;
            _LIN_S      <= 1'b1;
            _LIN_T      <= 1'b1;
        end else begin
            state       <= state_nx;
            dead_cnt    <= dead_nx;
            step_cnt    <= step_nx;
            rotateState <= rot_nx;
            pwm_cnt     <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) duty_q <= duty_cmd;
            duty        <= duty_nx;
            HIN_R       <= hin_nx[2];
            HIN_S       <= hin_nx[1];
            HIN_T       <= hin_nx[0];
            _LIN_R      <= ~lo_on[2];
            _LIN_S      <= ~lo_on[1];
            _LIN_T      <= ~lo_on[0];
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: directed scenarios with spec-derived constants
// plus a randomized run against a phase-level behavioural model.
`timescale 1ns/1ps
module tb_bldc_commutator;

    localparam int DT = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        dir = 1'b1;
    logic [15:0] period = 16'd0;
    logic [7:0]  duty_cmd = 8'd0;
    logic        duty;
    logic [2:0]  rotateState;
    logic        HIN_R, HIN_S, HIN_T, _LIN_R, _LIN_S, _LIN_T;
    logic [5:0]  gates;

    int n_cmp = 0;
    int n_bad = 0;
    int tcount = 0;

    // Model: mode 0=idle 1=dead 2=run, with countdown/elapsed counters.
    int   m_mode = 0, m_dead_left = 0, m_elapsed = 0, m_rot = 0, m_pwm = 0, m_dq = 0;
    logic m_duty = 1'b0;
    int   hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int   lo_ph [6] = '{1, 2, 2, 0, 0, 1};

    localparam logic [5:0] OFF = 6'b000111;

    bldc_commutator #(.DEAD_TIME(DT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .dir(dir),
        .period(period), .duty_cmd(duty_cmd), .duty(duty), .rotateState(rotateState),
        .HIN_R(HIN_R), .HIN_S(HIN_S), .HIN_T(HIN_T),
        ._LIN_R(_LIN_R), ._LIN_S(_LIN_S), ._LIN_T(_LIN_T)
    );

    assign gates = {HIN_R, HIN_S, HIN_T, _LIN_R, _LIN_S, _LIN_T};

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t, want finish before it", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge sys_clk) begin
        n_cmp++;
        if (((HIN_R & ~_LIN_R) | (HIN_S & ~_LIN_S) | (HIN_T & ~_LIN_T)) !== 1'b0) begin
            n_bad++;
            $display("FAIL shoot_through t=%0t got gates=%b, want no phase with HIN=1 and _LIN=0", $time, gates);
        end
    end

    function automatic logic [5:0] table_gates(input int r, input logic d);
        logic [2:0] hi, lo;
        hi = 3'b000;
        lo = 3'b111;
        hi[2 - hi_ph[r]] = d;
        lo[2 - lo_ph[r]] = 1'b0;
        return {hi, lo};
    endfunction

    function automatic logic [5:0] model_gates();
        return (m_mode == 2) ? table_gates(m_rot, m_duty) : OFF;
    endfunction

    task automatic model_step();
        if (!sys_rst_n) begin
            m_mode = 0; m_dead_left = 0; m_elapsed = 0; m_rot = 0;
            m_pwm = 0; m_dq = 0; m_duty = 1'b0;
            return;
        end
        m_duty = (m_pwm < m_dq);
        if (m_pwm == 255) m_dq = duty_cmd;
        m_pwm = (m_pwm + 1) % 256;
        if (!enable) begin
            m_mode = 0;
            m_elapsed = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_dead_left = DT;
        end else if (m_mode == 1) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_mode = 2;
                m_elapsed = 0;
            end
        end else if (period != 0) begin
            m_elapsed++;
            if (m_elapsed >= int'(period)) begin
                m_rot = dir ? (m_rot + 1) % 6 : (m_rot + 5) % 6;
                m_mode = 1;
                m_dead_left = DT;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        tcount++;
    endtask

    task automatic test_reset();
        enable = 1'b1; dir = 1'b1; period = 16'd100; duty_cmd = 8'd128;
        #1 sys_rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (duty !== 1'b0) begin n_bad++; $display("FAIL reset_duty got %b want 0", duty); end
        n_cmp++;
        if (rotateState !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", rotateState); end
        n_cmp++;
        if (gates !== OFF) begin n_bad++; $display("FAIL reset_gates got %b want %b", gates, OFF); end
    endtask

    task automatic test_startup();
        sys_rst_n = 1'b1;
        tcount = 0;
        for (int i = 1; i <= DT; i++) begin
            tick();
            n_cmp++;
            if (gates !== OFF) begin n_bad++; $display("FAIL startup_off tick %0d got %b want %b", i, gates, OFF); end
        end
        tick();
        n_cmp++;
        if (rotateState !== 3'd0) begin n_bad++; $display("FAIL startup_state got %0d want 0", rotateState); end
        n_cmp++;
        if (gates !== {m_duty, 2'b00, 3'b101}) begin
            n_bad++; $display("FAIL startup_drive got %b want %b", gates, {m_duty, 2'b00, 3'b101});
        end
    endtask

    task automatic test_forward();
        logic [2:0] prev;
        int waited;
        prev = rotateState;
        for (int k = 1; k <= 6; k++) begin
            waited = 0;
            while (rotateState === prev && waited < 300) begin tick(); waited++; end
            n_cmp++;
            if (rotateState !== 3'(k % 6)) begin n_bad++; $display("FAIL fwd_state got %0d want %0d", rotateState, k % 6); end
            n_cmp++;
            if (tcount !== 1 + 116 * k) begin n_bad++; $display("FAIL fwd_time got tick %0d want %0d", tcount, 1 + 116 * k); end
            prev = rotateState;
            for (int j = 0; j < DT; j++) begin
                if (j > 0) tick();
                n_cmp++;
                if (gates !== OFF) begin n_bad++; $display("FAIL fwd_dead step %0d tick %0d got %b want %b", k % 6, j, gates, OFF); end
            end
            tick();
            n_cmp++;
            if (gates !== table_gates(k % 6, m_duty)) begin
                n_bad++; $display("FAIL fwd_drive step %0d got %b want %b", k % 6, gates, table_gates(k % 6, m_duty));
            end
        end
    endtask

    task automatic test_reverse();
        int waited;
        dir = 1'b0;
        waited = 0;
        while (rotateState === 3'd0 && waited < 300) begin tick(); waited++; end
        n_cmp++;
        if (rotateState !== 3'd5) begin n_bad++; $display("FAIL rev_state got %0d want 5", rotateState); end
        repeat (DT) tick();
        n_cmp++;
        if (gates !== {2'b00, m_duty, 3'b101}) begin
            n_bad++; $display("FAIL rev_drive got %b want %b", gates, {2'b00, m_duty, 3'b101});
        end
    endtask

    task automatic test_duty();
        int vals [3] = '{0, 128, 255};
        int hi, waited;
        for (int v = 0; v < 3; v++) begin
            duty_cmd = 8'(vals[v]);
            repeat (512) tick();
            hi = 0;
            repeat (256) begin tick(); if (duty === 1'b1) hi++; end
            n_cmp++;
            if (hi !== vals[v]) begin n_bad++; $display("FAIL duty_frame cmd %0d got %0d high want %0d", vals[v], hi, vals[v]); end
        end
        duty_cmd = 8'd0;
        repeat (512) tick();
        waited = 0;
        while (tcount % 256 != 10 && waited < 300) begin tick(); waited++; end
        duty_cmd = 8'd255;
        hi = 0;
        do begin tick(); if (duty === 1'b1) hi++; end while (tcount % 256 != 0);
        n_cmp++;
        if (hi !== 0) begin n_bad++; $display("FAIL duty_midframe got %0d high want 0", hi); end
        hi = 0;
        repeat (256) begin tick(); if (duty === 1'b1) hi++; end
        n_cmp++;
        if (hi !== 255) begin n_bad++; $display("FAIL duty_nextframe got %0d high want 255", hi); end
        duty_cmd = 8'd128;
    endtask

    task automatic wait_run();
        int waited;
        waited = 0;
        while (m_mode != 2 && waited < 300) begin tick(); waited++; end
        n_cmp++;
        if (m_mode != 2) begin n_bad++; $display("FAIL wait_run timeout got mode %0d want 2", m_mode); end
    endtask

    task automatic test_enable_drop();
        int r, waited;
        wait_run();
        r = m_rot;
        enable = 1'b0;
        tick();
        n_cmp++;
        if (gates !== OFF || rotateState !== 3'(r)) begin
            n_bad++; $display("FAIL drop_run got gates=%b state=%0d want %b state=%0d", gates, rotateState, OFF, r);
        end
        repeat (5) tick();
        n_cmp++;
        if (gates !== OFF || rotateState !== 3'(r)) begin
            n_bad++; $display("FAIL idle_hold got gates=%b state=%0d want %b state=%0d", gates, rotateState, OFF, r);
        end
        enable = 1'b1;
        repeat (5) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if (gates !== OFF || rotateState !== 3'(r)) begin
            n_bad++; $display("FAIL drop_dead got gates=%b state=%0d want %b state=%0d", gates, rotateState, OFF, r);
        end
        enable = 1'b1;
        for (int i = 1; i <= DT; i++) begin
            tick();
            n_cmp++;
            if (gates !== OFF) begin n_bad++; $display("FAIL reenable_off tick %0d got %b want %b", i, gates, OFF); end
        end
        tick();
        n_cmp++;
        if (gates !== table_gates(r, m_duty)) begin
            n_bad++; $display("FAIL reenable_drive got %b want %b", gates, table_gates(r, m_duty));
        end
        waited = 0;
        while (!(m_mode == 2 && m_elapsed + 1 == int'(period)) && waited < 300) begin tick(); waited++; end
        r = m_rot;
        enable = 1'b0;
        tick();
        n_cmp++;
        if (gates !== OFF || rotateState !== 3'(r)) begin
            n_bad++; $display("FAIL drop_vs_advance got gates=%b state=%0d want %b state=%0d", gates, rotateState, OFF, r);
        end
        enable = 1'b1;
    endtask

    task automatic test_period_zero();
        int r, waited;
        wait_run();
        r = m_rot;
        period = 16'd0;
        repeat (300) begin
            tick();
            n_cmp++;
            if (rotateState !== 3'(r) || gates[2:0] !== table_gates(r, 1'b0)) begin
                n_bad++; $display("FAIL period0_hold got state=%0d lin=%b want state=%0d lin=%b",
                                  rotateState, gates[2:0], r, table_gates(r, 1'b0));
            end
        end
        period = 16'd3;
        waited = 0;
        while (rotateState === 3'(r) && waited < 10) begin tick(); waited++; end
        n_cmp++;
        if (rotateState !== 3'((r + 5) % 6)) begin
            n_bad++; $display("FAIL period_resume got %0d want %0d", rotateState, (r + 5) % 6);
        end
    endtask

    task automatic test_reset_midrun();
        wait_run();
        sys_rst_n = 1'b0;
        #2;
        n_cmp++;
        if (gates !== OFF || rotateState !== 3'd0 || duty !== 1'b0) begin
            n_bad++; $display("FAIL async_reset got gates=%b state=%0d duty=%b want %b 0 0", gates, rotateState, duty, OFF);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int i = 1; i <= DT; i++) begin
            tick();
            n_cmp++;
            if (gates !== OFF) begin n_bad++; $display("FAIL restart_off tick %0d got %b want %b", i, gates, OFF); end
        end
        tick();
        n_cmp++;
        if (rotateState !== 3'd0 || gates !== table_gates(0, m_duty)) begin
            n_bad++; $display("FAIL restart_drive got state=%0d gates=%b want 0 %b", rotateState, gates, table_gates(0, m_duty));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if (enable ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20)) enable = ~enable;
            if ($urandom_range(0, 99) < 5) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 4))
                    0: period = 16'd0;
                    1: period = 16'd1;
                    2: period = 16'($urandom_range(2, 8));
                    3: period = 16'($urandom_range(9, 60));
                    default: period = 16'($urandom_range(1, 300));
                endcase
            end
            if ($urandom_range(0, 99) < 2) duty_cmd = 8'($urandom_range(0, 255));
            if (sys_rst_n ? ($urandom_range(0, 999) < 3) : ($urandom_range(0, 1) == 1)) sys_rst_n = ~sys_rst_n;
            tick();
            n_cmp++;
            if (rotateState !== 3'(m_rot)) begin n_bad++; $display("FAIL rand_state cyc %0d got %0d want %0d", i, rotateState, m_rot); end
            n_cmp++;
            if (duty !== m_duty) begin n_bad++; $display("FAIL rand_duty cyc %0d got %b want %b", i, duty, m_duty); end
            n_cmp++;
            if (gates !== model_gates()) begin n_bad++; $display("FAIL rand_gates cyc %0d got %b want %b", i, gates, model_gates()); end
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_startup();
        test_forward();
        test_reverse();
        test_duty();
        test_enable_drop();
        test_period_zero();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
